alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 202 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/result bundle for alu_seq: operands and opcode in, result and flags out.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [3:0]       op_alu;
    logic             s_inm;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             div0;

    modport master (
        output start, op_alu, s_inm, a, b,
        input  ready, done, y, carry, overflow, zero, div0
    );

    modport slave (
        input  start, op_alu, s_inm, a, b,
        output ready, done, y, carry, overflow, zero, div0
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus bit-serial multiply and restoring divide.
// Result and flags are registered and change only on the edge that enters DONE.
module alu_seq #(
    parameter int unsigned WIDTH = 16
) (
    input logic        clk,
    input logic        reset,
    alu_seq_if.slave   bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    localparam logic [3:0] OpPass = 4'b0000;
    localparam logic [3:0] OpNot  = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSub  = 4'b0011;
    localparam logic [3:0] OpAnd  = 4'b0100;
    localparam logic [3:0] OpOr   = 4'b0101;
    localparam logic [3:0] OpNeg0 = 4'b0110;
    localparam logic [3:0] OpNeg1 = 4'b0111;
    localparam logic [3:0] OpMul  = 4'b1000;
    localparam logic [3:0] OpDiv  = 4'b1001;
    localparam logic [3:0] OpRem  = 4'b1010;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;   // product high half / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;   // multiplier bits / dividend-then-quotient bits
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             div0_q, div0_d;

    // Single-cycle datapath, driven straight from the request inputs
    logic [WIDTH:0]   add_sum, sub_dif;
    logic [WIDTH-1:0] sub_m, sub_s, neg_y, alu_y;
    logic             alu_c, alu_v, is_multi;

    always_comb begin
        alu_y   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        add_sum = {1'b0, bus.a} + {1'b0, bus.b};
        sub_m   = bus.s_inm ? bus.b : bus.a;
        sub_s   = bus.s_inm ? bus.a : bus.b;
        sub_dif = {1'b0, sub_m} - {1'b0, sub_s};
        neg_y   = (~bus.a) + WIDTH'(1);
        case (bus.op_alu)
            OpPass: alu_y = bus.a;
            OpNot:  alu_y = ~bus.a;
            OpAdd: begin
                alu_y = add_sum[WIDTH-1:0];
                alu_c = add_sum[WIDTH];
                alu_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                        (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OpSub: begin
                alu_y = sub_dif[WIDTH-1:0];
                alu_c = sub_dif[WIDTH];
                alu_v = (sub_m[WIDTH-1] != sub_s[WIDTH-1]) &&
                        (sub_dif[WIDTH-1] != sub_m[WIDTH-1]);
            end
            OpAnd:  alu_y = bus.a & bus.b;
            OpOr:   alu_y = bus.a | bus.b;
            OpNeg0, OpNeg1: begin
                alu_y = neg_y;
                alu_v = (bus.a == {1'b1, {(WIDTH - 1){1'b0}}});
            end
            default: ;
        endcase
        is_multi = (bus.op_alu == OpMul) || (bus.op_alu == OpDiv) || (bus.op_alu == OpRem);
    end

    // One iteration of the serial multiply and divide
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] div_rem, div_quo;
    logic             div_ge;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        // Remainder stays below the divisor, so the top bit of the difference is a pure borrow.
        // With b=0 this degenerates to quotient all ones and remainder equal to a.
        div_ge    = ~div_diff[WIDTH];
        div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo   = {lo_q[WIDTH-2:0], div_ge};
    end

    logic             res_load, res_c, res_v, res_d0;
    logic [WIDTH-1:0] res_y;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        y_d      = y_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        div0_d   = div0_q;
        res_load = 1'b0;
        res_y    = '0;
        res_c    = 1'b0;
        res_v    = 1'b0;
        res_d0   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    op_d = bus.op_alu;
                    if (is_multi) begin
                        state_d = StBusy;
                        cnt_d   = '0;
                        hi_d    = '0;
                        lo_d    = bus.a;
                        b_d     = bus.b;
                    end else begin
                        state_d  = StDone;
                        res_load = 1'b1;
                        res_y    = alu_y;
                        res_c    = alu_c;
                        res_v    = alu_v;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OpMul) begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end else begin
                    hi_d = div_rem;
                    lo_d = div_quo;
                end
                if (cnt_q == CntLast) begin
                    state_d  = StDone;
                    res_load = 1'b1;
                    if (op_q == OpMul) begin
                        res_y = {mul_sum[0], lo_q[WIDTH-1:1]};
                        res_v = |mul_sum[WIDTH:1];
                    end else begin
                        res_y  = (op_q == OpDiv) ? div_quo : div_rem;
                        res_d0 = (b_q == '0);
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (res_load) begin
            y_d     = res_y;
            carry_d = res_c;
            ovf_d   = res_v;
            zero_d  = (res_y == '0);
            div0_d  = res_d0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            y_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            y_q     <= y_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            div0_q  <= div0_d;
        end
    end

    assign bus.ready    = (state_q == StIdle);
    assign bus.done     = (state_q == StDone);
    assign bus.y        = y_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
    assign bus.div0     = div0_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=16 with hand-computed expected values.
module tb_alu_seq;
    localparam int unsigned W = 16;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   n_done;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE, scramble inputs after accept, measure latency to done.
    task automatic run_op(input string tag, input logic [3:0] op, input logic s,
                          input logic [15:0] a, input logic [15:0] b, input int exp_lat);
        int lat;
        bit busy_ok;
        bus.start  = 1'b1;
        bus.op_alu = op;
        bus.s_inm  = s;
        bus.a      = a;
        bus.b      = b;
        tick();
        bus.start  = 1'b0;
        bus.op_alu = 4'b0010;
        bus.s_inm  = ~s;
        bus.a      = ~a;
        bus.b      = ~b;
        lat        = 1;
        busy_ok    = 1'b1;
        while (bus.done !== 1'b1 && lat < 64) begin
            if (bus.ready !== 1'b0) busy_ok = 1'b0;
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        if (exp_lat > 1) chk({tag, " ready low while busy"}, 32'(busy_ok), 32'd1);
    endtask

    // Check result while done is high, then that done drops and ready returns.
    task automatic chk_res(input string tag, input logic [15:0] ey, input logic ec,
                           input logic ev, input logic ez, input logic ed);
        chk({tag, " y"}, bus.y, ey);
        chk({tag, " carry"}, bus.carry, ec);
        chk({tag, " overflow"}, bus.overflow, ev);
        chk({tag, " zero"}, bus.zero, ez);
        chk({tag, " div0"}, bus.div0, ed);
        tick();
        chk({tag, " done pulse ends"}, bus.done, 1'b0);
        chk({tag, " ready back"}, bus.ready, 1'b1);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        bus.start  = 1'b1;
        bus.op_alu = 4'b0010;
        bus.s_inm  = 1'b0;
        bus.a      = 16'h0001;
        bus.b      = 16'h0001;
        repeat (3) tick();
        chk("in reset done", bus.done, 1'b0);
        chk("in reset y", bus.y, 16'h0000);
        reset     = 1'b0;
        bus.start = 1'b0;
        chk("post reset ready", bus.ready, 1'b1);
        chk("post reset done", bus.done, 1'b0);
        chk("post reset y", bus.y, 16'h0000);
        chk("post reset flags", {bus.carry, bus.overflow, bus.zero, bus.div0}, 4'b0000);
        tick();
        chk("start under reset ignored", bus.done, 1'b0);

        run_op("add ovf", 4'b0010, 1'b0, 16'h7FFF, 16'h0001, 1);
        chk_res("add ovf", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("add carry", 4'b0010, 1'b0, 16'hFFFF, 16'h0001, 1);
        chk_res("add carry", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("sub a-b", 4'b0011, 1'b0, 16'h0003, 16'h0005, 1);
        chk_res("sub a-b", 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("sub b-a", 4'b0011, 1'b1, 16'h0003, 16'h0005, 1);
        chk_res("sub b-a", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sub ovf", 4'b0011, 1'b0, 16'h8000, 16'h0001, 1);
        chk_res("sub ovf", 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("pass", 4'b0000, 1'b0, 16'h1234, 16'hFFFF, 1);
        chk_res("pass", 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("not", 4'b0001, 1'b0, 16'h00FF, 16'h0000, 1);
        chk_res("not", 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("and", 4'b0100, 1'b0, 16'h0F0F, 16'h00FF, 1);
        chk_res("and", 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("or", 4'b0101, 1'b0, 16'h0F00, 16'h00F0, 1);
        chk_res("or", 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("neg one", 4'b0111, 1'b0, 16'h0001, 16'h0000, 1);
        chk_res("neg one", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);

        run_op("mul 256x256", 4'b1000, 1'b0, 16'h0100, 16'h0100, 17);
        chk_res("mul 256x256", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
        run_op("mul 3x5", 4'b1000, 1'b0, 16'h0003, 16'h0005, 17);
        chk_res("mul 3x5", 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("mul ffff sq", 4'b1000, 1'b0, 16'hFFFF, 16'hFFFF, 17);
        chk_res("mul ffff sq", 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("div 100/7", 4'b1001, 1'b0, 16'd100, 16'd7, 17);
        chk_res("div 100/7", 16'd14, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("rem 100%7", 4'b1010, 1'b0, 16'd100, 16'd7, 17);
        chk_res("rem 100%7", 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("div by 0", 4'b1001, 1'b0, 16'h1234, 16'h0000, 17);
        chk_res("div by 0", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("rem by 0", 4'b1010, 1'b0, 16'h1234, 16'h0000, 17);
        chk_res("rem by 0", 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("div exact", 4'b1001, 1'b0, 16'hFFFF, 16'h0003, 17);
        chk_res("div exact", 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);

        run_op("reserved op", 4'b1100, 1'b0, 16'h1234, 16'h5678, 1);
        chk("reserved y", bus.y, 16'h0000);
        chk("reserved c/v/d0", {bus.carry, bus.overflow, bus.div0}, 3'b000);
        tick();

        // Neg of most negative with start held into the DONE cycle
        n_done     = 0;
        bus.start  = 1'b1;
        bus.op_alu = 4'b0110;
        bus.a      = 16'h8000;
        bus.b      = 16'h0000;
        tick();
        bus.a = 16'h0005;
        for (int i = 0; i < 6; i++) begin
            if (bus.done === 1'b1) n_done++;
            if (i == 1) bus.start = 1'b0;
            if (i == 0) begin
                chk("neg min y", bus.y, 16'h8000);
                chk("neg min overflow", bus.overflow, 1'b1);
            end
            tick();
        end
        chk("neg single done", n_done, 1);

        // Multiply with start and operands churning while busy
        n_done     = 0;
        bus.start  = 1'b1;
        bus.op_alu = 4'b1000;
        bus.a      = 16'h0003;
        bus.b      = 16'h0005;
        tick();
        for (int i = 0; i < 25; i++) begin
            if (bus.done === 1'b1) n_done++;
            bus.start  = (i < 10);
            bus.op_alu = 4'b0010;
            bus.a      = 16'(i * 37);
            bus.b      = 16'(i + 1);
            tick();
        end
        bus.start = 1'b0;
        chk("busy start ignored done count", n_done, 1);
        chk("busy start ignored y", bus.y, 16'h000F);

        // Reset in the middle of a multiply
        bus.start  = 1'b1;
        bus.op_alu = 4'b1000;
        bus.a      = 16'h0100;
        bus.b      = 16'h0100;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort ready", bus.ready, 1'b1);
        chk("abort y", bus.y, 16'h0000);
        chk("abort flags", {bus.carry, bus.overflow, bus.zero, bus.div0}, 4'b0000);
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) n_done++;
            tick();
        end
        chk("abort no done", n_done, 0);
        run_op("add after abort", 4'b0010, 1'b0, 16'h0002, 16'h0003, 1);
        chk_res("add after abort", 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
